de_stage_reg: RTL and testbench
===============================

// Module: de_stage_reg
// PURPOSE
//  D->E pipeline register with built-in Tuse/Tnew stall detection for the 5-stage MIPS core.
//  Latches the decoded instruction, PC and GRF read data each cycle, feeding E_controller and the ALU.
//  On a RAW hazard it freezes F/D and injects a nop bubble into E.
//  An external hold freezes the whole front end, for future multi-cycle E units.
// PARAMETERS
//  WIDTH     32            datapath width (PC, instruction, GRF data)
//  RESET_PC  32'h0000_3000 E_pc value after reset
//  CNT_W     16            width of the stall performance counter
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-low reset
//  D_instr      in   WIDTH  instruction in D
//  D_pc         in   WIDTH  PC of D instruction
//  D_rs_data    in   WIDTH  GRF rs read data (already D-forwarded)
//  D_rt_data    in   WIDTH  GRF rt read data (already D-forwarded)
//  D_Tuse_rs    in   2      cycles until rs is needed; 2'b11 = rs unused
//  D_Tuse_rt    in   2      cycles until rt is needed; 2'b11 = rt unused
//  E_T_new      in   2      Tnew of the instruction now in E (from E_controller)
//  E_Wreg       in   5      destination of the instruction now in E (0 = none)
//  M_T_new      in   2      Tnew of the instruction now in M
//  M_Wreg       in   5      destination of the instruction now in M
//  hold         in   1      external freeze request
//  stall        out  1      to F/PC and F/D regs: keep current value (combinational)
//  E_instr      out  WIDTH  instruction in E
//  E_pc         out  WIDTH  PC of E instruction
//  E_rs_data    out  WIDTH  latched rs data
//  E_rt_data    out  WIDTH  latched rt data
//  E_valid      out  1      1 = real instruction, 0 = bubble/reset
//  stall_cnt    out  CNT_W  count of injected bubbles, saturating
// BEHAVIOUR
//  Reset, when reset==0 at a posedge: E_instr=0, E_rs_data=0, E_rt_data=0, E_valid=0, E_pc=RESET_PC, stall_cnt=0.
//   Reset has priority over all other inputs.
//  Hazard, combinational, for each src s in {rs=D_instr[25:21], rt=D_instr[20:16]}:
//   haz_s = (Tuse_s!=3) && (s!=0) && ((s==E_Wreg && Tuse_s<E_T_new) || (s==M_Wreg && Tuse_s<M_T_new)).
//   hz = haz_rs | haz_rt.
//   Register 0 never causes a stall.
//   E match and M match are checked independently; either one stalls.
//  stall = hold | hz. The output is not gated by reset.
//  At each posedge, with reset==1, priority top-down:
//   hold=1 : all E regs keep their value; stall_cnt unchanged. hold wins over hz.
//   hz=1   : bubble is injected. E_instr=0 (sll $0 nop), E_rs_data=0, E_rt_data=0, E_valid=0,
//            E_pc=D_pc. stall_cnt+=1 if it is below 2^CNT_W-1, else it stays unchanged.
//   else   : E_* <= D_* and E_valid=1.
//  Latency: 1 cycle from D to E. A bubble produces Tnew=0 and Wreg=0 in E, so a stall lasts at most 2 cycles
//   (lw followed by beq), and 1 cycle for lw followed by a dependent ALU op.
//  Reset mid-stall clears E. stall may still be high in the reset cycle; F/D is held, which is harmless.
// STRUCTURE
//  Package mips_pkg: opcode/funct constants (R, ORI, LUI, LW, SW, BEQ, JAL, ADD/SUB/JR funct),
//   TUSE_NONE=2'b11, TNEW_ALU=2'b01, TNEW_LOAD=2'b10, NOP_INSTR=32'h0.
//  Sub-module hazard_unit: purely combinational. Inputs are rs, rt, Tuse and E/M Tnew/Wreg; output is hz.
//   It is reused later for W-stage checks.
//  Top module: the register bank, the priority mux and the saturating counter.
// TESTING
//  1 reset=0 for 2 cycles -> E_pc=32'h3000, E_instr=0, E_valid=0, stall_cnt=0.
//  2 lw $1 in E (E_T_new=2, E_Wreg=1); D=add $2,$1,$3 (Tuse_rs=1)
//    -> stall=1; next E_instr=0, E_valid=0, stall_cnt=1.
//    Next cycle, with M_T_new=1 and E_T_new=0 -> stall=0, add enters E.
//  3 lw $1 in E; D=beq $1,$0 (Tuse 0) -> 2 stall cycles, stall_cnt+=2, beq reaches E after the 2nd bubble.
//  4 E_Wreg=0, E_T_new=2; D uses $0 -> no stall, D latched normally.
//    Same for sw $5 rt (Tuse_rt=2) after add $5 (E_T_new=1) -> no stall.
//  5 hold=1 together with a hazard -> E regs unchanged, stall=1, stall_cnt unchanged.
//    Drop hold -> bubble injected on the next cycle.
//  6 Force stall_cnt=16'hFFFE and trigger 3 bubbles -> it saturates at 16'hFFFF.
//    Assert reset mid-stall -> all outputs return to their reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and Tuse/Tnew codes for the decode/execute pipeline.
// The encoder helpers build instruction words from fields.
package mips_pkg;

    localparam logic [5:0] OP_R       = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    localparam logic [1:0] TUSE_NONE  = 2'b11;
    localparam logic [1:0] TNEW_ALU   = 2'b01;
    localparam logic [1:0] TNEW_LOAD  = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Source operand selector for the hazard comparators.
    typedef enum logic {
        SRC_RS = 1'b0,
        SRC_RT = 1'b1
    } src_sel_e;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_R, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/de_stage_reg_if.sv
// D->E boundary bundle: decoded operands in, E-stage state and stall back out.
interface de_stage_reg_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] D_instr;
    logic [WIDTH-1:0] D_pc;
    logic [WIDTH-1:0] D_rs_data;
    logic [WIDTH-1:0] D_rt_data;
    logic [1:0]       D_Tuse_rs;
    logic [1:0]       D_Tuse_rt;
    logic [1:0]       E_T_new;
    logic [4:0]       E_Wreg;
    logic [1:0]       M_T_new;
    logic [4:0]       M_Wreg;
    logic             hold;
    logic             stall;
    logic [WIDTH-1:0] E_instr;
    logic [WIDTH-1:0] E_pc;
    logic [WIDTH-1:0] E_rs_data;
    logic [WIDTH-1:0] E_rt_data;
    logic             E_valid;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output D_instr, D_pc, D_rs_data, D_rt_data, D_Tuse_rs, D_Tuse_rt,
               E_T_new, E_Wreg, M_T_new, M_Wreg, hold,
        input  stall, E_instr, E_pc, E_rs_data, E_rt_data, E_valid, stall_cnt
    );

    modport slave (
        input  D_instr, D_pc, D_rs_data, D_rt_data, D_Tuse_rs, D_Tuse_rt,
               E_T_new, E_Wreg, M_T_new, M_Wreg, hold,
        output stall, E_instr, E_pc, E_rs_data, E_rt_data, E_valid, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Combinational Tuse/Tnew RAW detector for two source registers against E and M producers.
// Kept free of pipeline state so the same block can check later stages.
module hazard_unit
    import mips_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [1:0] tuse_rs,
    input  logic [1:0] tuse_rt,
    input  logic [1:0] e_t_new,
    input  logic [4:0] e_wreg,
    input  logic [1:0] m_t_new,
    input  logic [4:0] m_wreg,
    output logic       hz
);
    logic [4:0] src  [2];
    logic [1:0] tuse [2];
    logic [1:0] haz;

    assign src[SRC_RS]  = rs;
    assign src[SRC_RT]  = rt;
    assign tuse[SRC_RS] = tuse_rs;
    assign tuse[SRC_RT] = tuse_rt;

    // $0 is hardwired, so a write to it never creates a dependency.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign haz[gi] = (tuse[gi] != TUSE_NONE) && (src[gi] != 5'd0) &&
                             (((src[gi] == e_wreg) && (tuse[gi] < e_t_new)) ||
                              ((src[gi] == m_wreg) && (tuse[gi] < m_t_new)));
        end
    endgenerate

    assign hz = |haz;

endmodule

// File: rtl/de_stage_reg.sv
// D->E pipeline register: latches the decoded instruction, injects a nop bubble on RAW hazards,
// freezes on external hold and counts injected bubbles with a saturating counter.
module de_stage_reg
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
    parameter int               CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    de_stage_reg_if.slave bus
);
    logic             hz;
    logic [WIDTH-1:0] e_instr_reg, e_instr_next;
    logic [WIDTH-1:0] e_pc_reg, e_pc_next;
    logic [WIDTH-1:0] e_rs_data_reg, e_rs_data_next;
    logic [WIDTH-1:0] e_rt_data_reg, e_rt_data_next;
    logic             e_valid_reg, e_valid_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

    hazard_unit u_hazard (
        .rs      (bus.D_instr[25:21]),
        .rt      (bus.D_instr[20:16]),
        .tuse_rs (bus.D_Tuse_rs),
        .tuse_rt (bus.D_Tuse_rt),
        .e_t_new (bus.E_T_new),
        .e_wreg  (bus.E_Wreg),
        .m_t_new (bus.M_T_new),
        .m_wreg  (bus.M_Wreg),
        .hz      (hz)
    );

    // Front end holds on either cause; deliberately not masked by reset.
    assign bus.stall = bus.hold | hz;

    always_comb begin
        e_instr_next   = e_instr_reg;
        e_pc_next      = e_pc_reg;
        e_rs_data_next = e_rs_data_reg;
        e_rt_data_next = e_rt_data_reg;
        e_valid_next   = e_valid_reg;
        stall_cnt_next = stall_cnt_reg;
        if (bus.hold) begin
            // everything keeps its value
        end else if (hz) begin
            // Bubble carries the D PC so E still has a meaningful PC for debug/exceptions.
            e_instr_next   = WIDTH'(NOP_INSTR);
            e_pc_next      = bus.D_pc;
            e_rs_data_next = '0;
            e_rt_data_next = '0;
            e_valid_next   = 1'b0;
            if (stall_cnt_reg != '1)
                stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end else begin
            e_instr_next   = bus.D_instr;
            e_pc_next      = bus.D_pc;
            e_rs_data_next = bus.D_rs_data;
            e_rt_data_next = bus.D_rt_data;
            e_valid_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_instr_reg   <= '0;
            e_pc_reg      <= RESET_PC;
            e_rs_data_reg <= '0;
            e_rt_data_reg <= '0;
            e_valid_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            e_instr_reg   <= e_instr_next;
            e_pc_reg      <= e_pc_next;
            e_rs_data_reg <= e_rs_data_next;
            e_rt_data_reg <= e_rt_data_next;
            e_valid_reg   <= e_valid_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign bus.E_instr   = e_instr_reg;
    assign bus.E_pc      = e_pc_reg;
    assign bus.E_rs_data = e_rs_data_reg;
    assign bus.E_rt_data = e_rt_data_reg;
    assign bus.E_valid   = e_valid_reg;
    assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_de_stage_reg.sv
// Directed bench for de_stage_reg; a second instance with a 2-bit counter shares the stimulus
// so counter saturation is reached in a handful of bubbles.
module tb_de_stage_reg;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    de_stage_reg_if #(.WIDTH(32), .CNT_W(16)) dut_if ();
    de_stage_reg_if #(.WIDTH(32), .CNT_W(2))  sat_if ();

    de_stage_reg #(.WIDTH(32), .RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    de_stage_reg #(.WIDTH(32), .RESET_PC(32'h0000_3000), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_if.slave)
    );

    assign sat_if.D_instr   = dut_if.D_instr;
    assign sat_if.D_pc      = dut_if.D_pc;
    assign sat_if.D_rs_data = dut_if.D_rs_data;
    assign sat_if.D_rt_data = dut_if.D_rt_data;
    assign sat_if.D_Tuse_rs = dut_if.D_Tuse_rs;
    assign sat_if.D_Tuse_rt = dut_if.D_Tuse_rt;
    assign sat_if.E_T_new   = dut_if.E_T_new;
    assign sat_if.E_Wreg    = dut_if.E_Wreg;
    assign sat_if.M_T_new   = dut_if.M_T_new;
    assign sat_if.M_Wreg    = dut_if.M_Wreg;
    assign sat_if.hold      = dut_if.hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_e(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt, input logic valid,
                         input logic [15:0] cnt, input logic [1:0] sat_cnt);
        chk({tag, ".E_instr"},   dut_if.E_instr,   instr);
        chk({tag, ".E_pc"},      dut_if.E_pc,      pc);
        chk({tag, ".E_rs_data"}, dut_if.E_rs_data, rs);
        chk({tag, ".E_rt_data"}, dut_if.E_rt_data, rt);
        chk({tag, ".E_valid"},   32'(dut_if.E_valid), 32'(valid));
        chk({tag, ".stall_cnt"}, 32'(dut_if.stall_cnt), 32'(cnt));
        chk({tag, ".sat_cnt"},   32'(sat_if.stall_cnt), 32'(sat_cnt));
        $display("txn %-10s E_instr=%h E_pc=%h valid=%0b stall_cnt=%0d sat_cnt=%0d",
                 tag, dut_if.E_instr, dut_if.E_pc, dut_if.E_valid, dut_if.stall_cnt,
                 sat_if.stall_cnt);
    endtask

    task automatic set_d(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [1:0] tuse_rs, input logic [1:0] tuse_rt);
        dut_if.D_instr   = instr;
        dut_if.D_pc      = pc;
        dut_if.D_Tuse_rs = tuse_rs;
        dut_if.D_Tuse_rt = tuse_rt;
    endtask

    task automatic set_em(input logic [1:0] e_tn, input logic [4:0] e_w,
                          input logic [1:0] m_tn, input logic [4:0] m_w);
        dut_if.E_T_new = e_tn;
        dut_if.E_Wreg  = e_w;
        dut_if.M_T_new = m_tn;
        dut_if.M_Wreg  = m_w;
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        chk({tag, ".stall"}, 32'(dut_if.stall), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] add_i, beq_i, add4_i, sw_i, ori_i;

    initial begin
        add_i  = enc_r(5'd1, 5'd3, 5'd2, FUNCT_ADD);    // add $2,$1,$3
        beq_i  = enc_i(OP_BEQ, 5'd1, 5'd0, 16'd4);      // beq $1,$0,4
        add4_i = enc_r(5'd0, 5'd0, 5'd4, FUNCT_ADD);    // add $4,$0,$0
        sw_i   = enc_i(OP_SW, 5'd29, 5'd5, 16'd0);      // sw $5,0($29)
        ori_i  = enc_i(OP_ORI, 5'd0, 5'd5, 16'd1);      // ori $5,$0,1

        reset = 1'b0;
        dut_if.hold      = 1'b0;
        dut_if.D_rs_data = 32'h0000_AAAA;
        dut_if.D_rt_data = 32'h0000_BBBB;
        set_d(32'h0, 32'h0, TUSE_NONE, TUSE_NONE);
        set_em(2'd0, 5'd0, 2'd0, 5'd0);

        // 1: reset for two cycles
        tick();
        tick();
        chk_e("reset", 32'h0, 32'h3000, 32'h0, 32'h0, 1'b0, 16'd0, 2'd0);
        reset = 1'b1;

        // 2: lw $1 in E, add $2,$1,$3 in D -> one bubble
        set_em(TNEW_LOAD, 5'd1, 2'd0, 5'd0);
        set_d(add_i, 32'h3004, 2'd1, 2'd1);
        chk_stall("lw_add", 1'b1);
        tick();
        chk_e("lw_add_b", 32'h0, 32'h3004, 32'h0, 32'h0, 1'b0, 16'd1, 2'd1);
        set_em(2'd0, 5'd0, TNEW_ALU, 5'd1);
        chk_stall("lw_add_go", 1'b0);
        tick();
        chk_e("add_in_E", 32'h0023_1020, 32'h3004, 32'hAAAA, 32'hBBBB, 1'b1, 16'd1, 2'd1);

        // 3: lw $1 in E, beq $1,$0 in D -> two bubbles (second from M match)
        set_em(TNEW_LOAD, 5'd1, 2'd0, 5'd0);
        set_d(beq_i, 32'h3008, 2'd0, 2'd0);
        chk_stall("beq_s1", 1'b1);
        tick();
        chk_e("beq_b1", 32'h0, 32'h3008, 32'h0, 32'h0, 1'b0, 16'd2, 2'd2);
        set_em(2'd0, 5'd0, TNEW_ALU, 5'd1);
        chk_stall("beq_s2", 1'b1);
        tick();
        chk_e("beq_b2", 32'h0, 32'h3008, 32'h0, 32'h0, 1'b0, 16'd3, 2'd3);
        set_em(2'd0, 5'd0, 2'd0, 5'd0);
        chk_stall("beq_go", 1'b0);
        tick();
        chk_e("beq_in_E", 32'h1020_0004, 32'h3008, 32'hAAAA, 32'hBBBB, 1'b1, 16'd3, 2'd3);

        // 4: no-stall cases: $0 source, Tuse >= Tnew, unused rt
        set_em(TNEW_LOAD, 5'd0, 2'd0, 5'd0);
        set_d(add4_i, 32'h300C, 2'd1, 2'd1);
        chk_stall("reg0", 1'b0);
        tick();
        chk_e("reg0_E", 32'h0000_2020, 32'h300C, 32'hAAAA, 32'hBBBB, 1'b1, 16'd3, 2'd3);
        set_em(TNEW_ALU, 5'd5, 2'd0, 5'd0);
        set_d(sw_i, 32'h3010, 2'd1, 2'd2);
        chk_stall("sw_rt", 1'b0);
        tick();
        chk_e("sw_E", 32'hAFA5_0000, 32'h3010, 32'hAAAA, 32'hBBBB, 1'b1, 16'd3, 2'd3);
        set_em(TNEW_LOAD, 5'd5, 2'd0, 5'd0);
        set_d(ori_i, 32'h3014, 2'd1, TUSE_NONE);
        dut_if.D_rs_data = 32'h0000_0011;
        dut_if.D_rt_data = 32'h0000_0022;
        chk_stall("rt_unused", 1'b0);
        tick();
        chk_e("ori_E", 32'h3405_0001, 32'h3014, 32'h11, 32'h22, 1'b1, 16'd3, 2'd3);

        // 5: hold with a hazard freezes E; dropping hold injects the bubble
        dut_if.D_rs_data = 32'h0000_AAAA;
        dut_if.D_rt_data = 32'h0000_BBBB;
        set_em(TNEW_LOAD, 5'd1, 2'd0, 5'd0);
        set_d(add_i, 32'h3018, 2'd1, 2'd1);
        dut_if.hold = 1'b1;
        chk_stall("hold_hz", 1'b1);
        tick();
        chk_e("hold_E", 32'h3405_0001, 32'h3014, 32'h11, 32'h22, 1'b1, 16'd3, 2'd3);
        dut_if.hold = 1'b0;
        chk_stall("unhold", 1'b1);
        tick();
        chk_e("unhold_b", 32'h0, 32'h3018, 32'h0, 32'h0, 1'b0, 16'd4, 2'd3);
        set_em(2'd0, 5'd0, 2'd0, 5'd0);
        dut_if.hold = 1'b1;
        chk_stall("hold_only", 1'b1);
        tick();
        chk_e("hold_only_E", 32'h0, 32'h3018, 32'h0, 32'h0, 1'b0, 16'd4, 2'd3);
        dut_if.hold = 1'b0;

        // 6: three more bubbles; 2-bit counter stays saturated at 3
        set_em(TNEW_LOAD, 5'd1, 2'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            set_d(add_i, 32'h3020 + 32'(i * 4), 2'd1, 2'd1);
            tick();
            chk_e("sat_b", 32'h0, 32'h3020 + 32'(i * 4), 32'h0, 32'h0, 1'b0,
                  16'(5 + i), 2'd3);
        end

        // reset mid-stall: stall still visible, state returns to reset values
        reset = 1'b0;
        chk_stall("rst_stall", 1'b1);
        tick();
        chk_e("rst_mid", 32'h0, 32'h3000, 32'h0, 32'h0, 1'b0, 16'd0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
